// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared definitions for the data memory responder: funct3 codes,
//            FSM state type, opcodes shared with the control decoder, and
//            helpers for byte-enable generation and load extension.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Lanes touched by an access of the given size; unsupported codes touch none.
  function automatic logic [3:0] byte_en(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: byte_en = 4'b0001;
      F3_H, F3_HU: byte_en = 4'b0011;
      F3_W:        byte_en = 4'b1111;
      default:     byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic f3_supported(input logic [2:0] f3);
    f3_supported = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Extend the little-endian word read at the access address to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      F3_B:    load_extend = {{24{w[7]}}, w[7:0]};
      F3_H:    load_extend = {{16{w[15]}}, w[15:0]};
      F3_W:    load_extend = w;
      F3_BU:   load_extend = {24'b0, w[7:0]};
      F3_HU:   load_extend = {16'b0, w[15:0]};
      default: load_extend = 32'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Brief    : Request/response bundle between the control path (master) and
//            the data memory responder (slave). The error signal exists only
//            when DMEM_RANGE_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;

  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [2:0]  funct3;
  logic [31:0] readData;
  logic        busy;
  logic        done;
`ifdef DMEM_RANGE_CHECK_EN
  logic        error;

  modport master (
    output memRead, memWrite, address, writeData, funct3,
    input  readData, busy, done, error
  );

  modport slave (
    input  memRead, memWrite, address, writeData, funct3,
    output readData, busy, done, error
  );
`else
  modport master (
    output memRead, memWrite, address, writeData, funct3,
    input  readData, busy, done
  );

  modport slave (
    input  memRead, memWrite, address, writeData, funct3,
    output readData, busy, done
  );
`endif

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_byte_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_byte_array
// Brief    : 2**ADDR_W x 8 storage with a 4-lane byte-enable write port and a
//            combinational 4-byte read port. Lane n addresses byte
//            (addr_i + n) mod 2**ADDR_W, so accesses wrap past the top byte.
//            ADDR_W must be at least 2 so the four lanes are distinct.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic [ADDR_W-1:0] addr_i,
  input  wire logic [3:0]        we_i,
  input  wire logic [31:0]       wdata_i,
  output logic      [31:0]       rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] lane_addr [4];

  generate
    for (genvar g = 0; g < 4; g++) begin : g_lane
      assign lane_addr[g]      = addr_i + ADDR_W'(g);
      assign rdata_o[8*g +: 8] = mem_q[lane_addr[g]];
    end
  endgenerate

  // Clear every byte on reset; otherwise write each enabled lane.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (we_i[l]) begin
          mem_q[lane_addr[l]] <= wdata_i[8*l +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Byte-addressed data memory for the multicycle core. Captures a
//            load/store request in IDLE, waits LATENCY cycles in WAIT, commits
//            at the last WAIT edge and pulses done for one cycle in DONE.
//            Supports lb/lh/lw/lbu/lhu and sb/sh/sw, little-endian, with
//            address wrap modulo 2**ADDR_W.
//            Optional macro DMEM_RANGE_CHECK_EN adds an error output that
//            flags out-of-range, misaligned or unsupported accesses and
//            suppresses their effect.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input wire logic clock,
  input wire logic reset,
  data_mem_responder_if.slave bus
);

  localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic              store_q;
  logic [31:0]       rdata_q;
  logic              busy_q;
  logic              done_q;

  logic              commit_d;
  logic              ok_d;
  logic [3:0]        we_d;
  logic [31:0]       word_d;

  assign commit_d = (state_q == WAIT) && (cnt_q == 4'd0);

`ifdef DMEM_RANGE_CHECK_EN
  logic hi_nz_q;
  logic error_q;
  logic err_d;

  assign err_d = hi_nz_q ||
                 (((f3_q == F3_H) || (f3_q == F3_HU)) && addr_q[0]) ||
                 ((f3_q == F3_W) && (addr_q[1:0] != 2'b00)) ||
                 !f3_supported(f3_q);
  assign ok_d  = !err_d;
  assign bus.error = error_q;
`else
  // Upper address bits do not take part in addressing in this build.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.address[31:ADDR_W];
  assign ok_d = 1'b1;
`endif

  // Writes land at the commit edge only; unsupported sizes enable no lanes.
  assign we_d = (commit_d && store_q && ok_d) ? byte_en(f3_q) : 4'b0000;

  dmem_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .addr_i  (addr_q),
    .we_i    (we_d),
    .wdata_i (wdata_q),
    .rdata_o (word_d)
  );

  // Request sequencer: capture, count down latency, commit, pulse done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      store_q <= 1'b0;
      rdata_q <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      hi_nz_q <= 1'b0;
      error_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.memRead || bus.memWrite) begin
            addr_q  <= bus.address[ADDR_W-1:0];
            wdata_q <= bus.writeData;
            f3_q    <= bus.funct3;
            // A simultaneous read and write is serviced as a store.
            store_q <= bus.memWrite;
            cnt_q   <= c_cnt_init;
            busy_q  <= 1'b1;
            state_q <= WAIT;
`ifdef DMEM_RANGE_CHECK_EN
            hi_nz_q <= |bus.address[31:ADDR_W];
`endif
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
            if (!store_q && ok_d) begin
              rdata_q <= load_extend(f3_q, word_d);
            end
`ifdef DMEM_RANGE_CHECK_EN
            error_q <= err_d;
`endif
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
`ifdef DMEM_RANGE_CHECK_EN
          error_q <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.readData = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed self-checking bench for data_mem_responder
//            (ADDR_W=8, LATENCY=2). Extra error-output checks are compiled
//            when DMEM_RANGE_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   last_lat;
  int   last_busy;
  logic last_err;
  int   ndone;

  data_mem_responder_if bus();

  data_mem_responder #(
    .ADDR_W  (8),
    .LATENCY (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete request; records latency (in negedge samples after the
  // accepting edge), number of busy samples and error seen with done.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] f3);
    logic got;
    @(negedge clock);
    bus.memRead   = rd;
    bus.memWrite  = wr;
    bus.address   = addr;
    bus.writeData = data;
    bus.funct3    = f3;
    @(negedge clock);
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    last_lat  = -1;
    last_busy = 0;
    last_err  = 1'b0;
    got       = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      if (bus.busy === 1'b1) last_busy++;
      if (bus.done === 1'b1) begin
        last_lat = i;
        got      = 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
        last_err = bus.error;
`endif
      end else begin
        @(negedge clock);
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    @(negedge clock);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.memRead   = 1'b0;
    bus.memWrite  = 1'b0;
    bus.address   = 32'd0;
    bus.writeData = 32'd0;
    bus.funct3    = 3'b000;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check("rst_readData", bus.readData, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);

    access(1'b1, 1'b0, 32'h10, 32'h0, 3'b100);
    check("lbu_10", bus.readData, 32'h0);
    check("lbu_10_lat", last_lat, 32'd3);

    access(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 3'b010);
    check("sw_lat", last_lat, 32'd3);
    check("sw_busy", last_busy, 32'd3);
    check("sw_keeps_rd", bus.readData, 32'h0);
    check("idle_busy", {31'b0, bus.busy}, 32'h0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
    check("lw_20", bus.readData, 32'hDEADBEEF);
    check("lw_lat", last_lat, 32'd3);
    check("lw_busy", last_busy, 32'd3);

`ifdef DMEM_RANGE_CHECK_EN
    access(1'b1, 1'b0, 32'h21, 32'h0, 3'b010);
    check("err_lw_21", {31'b0, last_err}, 32'h1);
    check("err_lw_21_rd", bus.readData, 32'hDEADBEEF);
    check("err_lw_21_lat", last_lat, 32'd3);
`endif

    access(1'b0, 1'b1, 32'h05, 32'h00000080, 3'b000);
    check("sb_keeps_rd", bus.readData, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h05, 32'h0, 3'b000);
    check("lb_05", bus.readData, 32'hFFFFFF80);
    access(1'b1, 1'b0, 32'h05, 32'h0, 3'b100);
    check("lbu_05", bus.readData, 32'h00000080);
    access(1'b1, 1'b0, 32'h04, 32'h0, 3'b010);
    check("lw_04", bus.readData, 32'h00008000);

`ifndef DMEM_RANGE_CHECK_EN
    access(1'b0, 1'b1, 32'hFF, 32'h00001234, 3'b001);
    access(1'b1, 1'b0, 32'hFF, 32'h0, 3'b101);
    check("lhu_ff_wrap", bus.readData, 32'h00001234);
    access(1'b1, 1'b0, 32'hFF, 32'h0, 3'b100);
    check("lbu_ff", bus.readData, 32'h00000034);
    access(1'b1, 1'b0, 32'h00, 32'h0, 3'b100);
    check("lbu_00", bus.readData, 32'h00000012);
    access(1'b1, 1'b0, 32'hFE, 32'h0, 3'b010);
    check("lw_fe_wrap", bus.readData, 32'h00123400);
    access(1'b1, 1'b0, 32'h0100_0020, 32'h0, 3'b010);
    check("lw_hi_ignored", bus.readData, 32'hDEADBEEF);

    access(1'b1, 1'b0, 32'h20, 32'h0, 3'b011);
    check("ld_bad_f3", bus.readData, 32'h0);
    check("ld_bad_f3_lat", last_lat, 32'd3);
    access(1'b0, 1'b1, 32'h60, 32'hCAFEF00D, 3'b111);
    access(1'b1, 1'b0, 32'h60, 32'h0, 3'b010);
    check("st_bad_f3", bus.readData, 32'h0);
`endif

    access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
    access(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 3'b010);
    check("rw_keeps_rd", bus.readData, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h40, 32'h0, 3'b010);
    check("rw_stored", bus.readData, 32'hA5A5A5A5);

    // Store at 0x50, then a read request pulsed while in WAIT.
    @(negedge clock);
    bus.memWrite  = 1'b1;
    bus.address   = 32'h50;
    bus.writeData = 32'h0BADF00D;
    bus.funct3    = 3'b010;
    @(negedge clock);
    bus.memWrite = 1'b0;
    bus.memRead  = 1'b1;
    bus.address  = 32'h20;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clock);
      bus.memRead = 1'b0;
    end
    check("wait_req_one_done", ndone, 32'd1);
    check("wait_req_idle", {31'b0, bus.busy}, 32'h0);
    check("wait_req_rd", bus.readData, 32'hA5A5A5A5);
    access(1'b1, 1'b0, 32'h50, 32'h0, 3'b010);
    check("lw_50", bus.readData, 32'h0BADF00D);

    // Reset asserted while the store is in WAIT.
    @(negedge clock);
    bus.memWrite  = 1'b1;
    bus.address   = 32'h30;
    bus.writeData = 32'h11223344;
    bus.funct3    = 3'b010;
    @(negedge clock);
    bus.memWrite = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    check("abort_done", {31'b0, bus.done}, 32'h0);
    check("abort_rd", bus.readData, 32'h0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clock);
    end
    check("abort_no_done", ndone, 32'd0);
    access(1'b1, 1'b0, 32'h30, 32'h0, 3'b100);
    check("abort_byte30", bus.readData, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Byte-addressed data memory that services the load/store requests raised by the main control decoder. It samples memRead/memWrite, the ALU-computed address, rs2 write data and funct3. It then completes the access after a fixed latency and pulses done so the multicycle sequencer can advance. It implements lb/lh/lw/lbu/lhu and sb/sh/sw, little-endian.

Parameters:
ADDR_W, 8, byte-address bits used; storage depth is 2**ADDR_W bytes
LATENCY, 2, cycles spent in WAIT before completion; legal range 1..15

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
memRead  input  1  load request from control
memWrite  input  1  store request from control
address  input  32  byte address from ALU result
writeData  input  32  store data (rs2)
funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
readData  output  32  load result, extended to 32 bits
busy  output  1  request in progress
done  output  1  one-cycle completion pulse

Behaviour:
- One clock. Reset is synchronous and active-high; clock and reset ports are named clock and reset.
- Reset: state=IDLE, readData=0, busy=0, done=0, latency counter=0, all storage bytes cleared to 0.
- Reset mid-operation aborts the access: no write is committed and the block returns to the reset values.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - memRead|memWrite sampled high at an edge -> capture address[ADDR_W-1:0], writeData and funct3; set counter=LATENCY-1; go to WAIT.
  - busy=1 from the next cycle.
- Request priority: memWrite and memRead both high -> treated as a store; the read is ignored.
- WAIT:
  - Counter nonzero -> decrement.
  - Counter==0 -> commit the access at this edge and go to DONE.
  - Request inputs are ignored while in WAIT and DONE.
- DONE: busy=1, done=1 for exactly one cycle, then IDLE. A new request can be accepted at the edge leaving DONE->IDLE+1, i.e. no back-to-back acceptance.
- Latency: accept at edge N -> done high in the cycle following edge N+LATENCY.
- Store commit:
  - sb writes byte A.
  - sh writes A, A+1.
  - sw writes A..A+3.
  - writeData low bits, little-endian.
- Load commit: readData is loaded at the commit edge.
  - lb/lh: sign-extended.
  - lbu/lhu: zero-extended.
  - lw: full word.
- readData holds its value until the next load commits; stores do not alter readData.
- Address arithmetic is modulo 2**ADDR_W; multi-byte accesses crossing the top byte wrap to byte 0. address[31:ADDR_W] is ignored.
- No alignment requirement.
- Unsupported funct3 (011, 110, 111): no write; a load yields readData=0. done still pulses.

Optional Feature:
DMEM_RANGE_CHECK_EN
- Defined:
  - Adds output error (1 bit, reset 0), valid only while done=1.
  - error=1 when address[31:ADDR_W]!=0, or when a halfword access is at an odd address, or when a word access has address[1:0]!=0, or when funct3 is unsupported.
  - On error: no write, readData unchanged, timing unchanged.
- Undefined: error port is absent; wrap/ignore behaviour as above.

Decomposition:
- Shared package (dmem_pkg):
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - state enum IDLE/WAIT/DONE.
  - opcode constants OP_LOAD=0000011 and OP_STORE=0100011, shared with the control decoder.
- One sub-module, dmem_byte_array: 2**ADDR_W x 8 storage with 4-lane byte-enable write, 4-byte read port and wrapped lane addressing.
- The FSM, extension and latency counter stay in the top module.

Test Plan:
- Reset held 2 cycles, then released -> readData=0, busy=0, done=0; lbu at address 0x10 returns 0x00000000.
- sw 0xDEADBEEF @0x20, then lw @0x20 with LATENCY=2 -> done in the 3rd cycle after each accept; readData=0xDEADBEEF; busy high for 3 cycles.
- sb 0x80 @0x05, then lb @0x05 -> readData=0xFFFFFF80; lbu @0x05 -> 0x00000080.
- sh 0x1234 @0xFF (ADDR_W=8) -> byte 0xFF=0x34 and byte 0x00=0x12; lhu @0xFF -> 0x00001234.
- memRead=memWrite=1 with sw 0xA5A5A5A5 @0x40 -> the store is committed and readData is unchanged. A request pulsed during WAIT is ignored, with a single done pulse.
- sw 0x11223344 @0x30, with reset asserted in WAIT -> byte 0x30 stays 0 and done never pulses. With DMEM_RANGE_CHECK_EN, lw @0x31 -> error=1 with done and readData unchanged.
